data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//   Data-side memory controller directly downstream of the CPU load/store path.
//   Decodes the CPU byte address into on-chip RAM or memory-mapped I/O (LEDs, switches, timer).
//   On stores, steers sub-word data onto the correct byte lanes.
//   On loads, returns read data right-aligned so the CPU's sign/zero extension on bits [15:0]/[7:0] is correct.
// PARAMETERS
//   RAM_WORDS  128    32-bit words of data RAM; RAM occupies byte addresses 0x000..0x1FF
//   IO_W       10     width of LED output and switch input
//   TMR_RST    32'hFFFF_FFFF  reset value of timer compare register
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   mem_we     in   1   store strobe, one write per cycle while high
//   mem_addr   in   10  byte address (CPU ALU result)
//   mem_size   in   3   funct3: 0/4=byte, 1/5=half, 2=word, others=word
//   mem_wdata  in   32  store data, LSB-aligned (byte in [7:0], half in [15:0])
//   mem_rdata  out  32  load data, LSB-aligned, registered
//   sw_in      in   IO_W  asynchronous switch inputs
//   led_out    out  IO_W  LED register
//   timer_irq  out  1   level interrupt = status.match & ctrl.irq_en
// BEHAVIOUR
//   Map (byte addr):
//     000-1FF  RAM
//     200  LED (RW)
//     204  SW (RO)
//     208  TCOUNT (RO)
//     20C  TCMP (RW)
//     210  TCTRL (RW)
//     214  STATUS (W1C)
//     other reads return 0; other writes are ignored.
//   Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
//     A misaligned store is dropped and sets STATUS[1].
//     A misaligned load returns 0 and sets STATUS[1].
//   Store lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],0}+1:+0; word -> all 4 lanes.
//     MMIO registers take a full-word write only; sub-word stores to MMIO are dropped and set STATUS[1].
//   Load: mem_rdata is updated every cycle from the previous cycle's address (latency 1, no read enable).
//     RAM word is shifted right by 8*addr[1:0] (byte) or 16*addr[1] (half), upper bits zero-filled.
//   Same-cycle load+store to one word: mem_rdata returns old data (read-before-write).
//   sw_in: 2-flop synchroniser; SW reads the second flop.
//   TCTRL bits:
//     [0] enable
//     [1] autoreload
//     [2] irq_en
//     [3] clear (self-clearing strobe, reads 0)
//   Timer (when compiled in):
//     TCOUNT increments each cycle while enable=1.
//     When TCOUNT==TCMP and enable=1: set STATUS[0].
//       If autoreload=1, TCOUNT<=0 next cycle; otherwise TCOUNT keeps counting and wraps at 2^32-1 -> 0.
//     clear=1 forces TCOUNT<=0 and overrides the increment.
//   STATUS: bit0 match, bit1 misalign; sticky; write 1 to clear. Same-cycle set and clear: set wins.
//   Reset values:
//     mem_rdata=0, led_out=0, TCOUNT=0, TCTRL=0, TCMP=TMR_RST, STATUS=0, timer_irq=0, sync flops=0
//     RAM contents are not reset.
//   Reset asserted mid-store: the write is suppressed in that cycle.
// CONFIGURATION
//   DMEM_TIMER_EN defined:
//     timer logic present; TCOUNT/TCMP/TCTRL behave as above.
//   DMEM_TIMER_EN undefined:
//     no timer flops; 208/20C/210 read 0; writes are ignored (not misaligned).
//     STATUS[0] is tied 0; timer_irq is tied 0.
// STRUCTURE
//   Package dmem_pkg:
//     address offsets (LED_A, SW_A, TCNT_A, TCMP_A, TCTRL_A, STAT_A, RAM_TOP)
//     size enum {SZ_BYTE, SZ_HALF, SZ_WORD} decoded from funct3
//     TCTRL bit indices
//   Sub-module dmem_ram:
//     RAM_WORDS x 32, 4 byte-enables, synchronous read, read-before-write.
//   Top module holds decode, lane steering, MMIO registers, timer and synchroniser.
// TESTING
//   Byte stores 0xAA@0x001, 0xBB@0x002; word load @0x000 -> 0x00BBAA00; byte load @0x002 -> 0x000000BB.
//   Half store 0x1234@0x006; half load @0x006 -> 0x00001234; word @0x004 -> 0x12340000.
//   Word store @0x003 -> RAM unchanged, STATUS=0x2; write 0x2 to 0x214 -> STATUS=0.
//   Word store 0x3FF to 0x200 -> led_out=0x3FF; sw_in=0x155 -> load 0x204 returns 0x155 from the 3rd cycle on.
//   TCMP=5, TCTRL=0x7 -> STATUS[0] and timer_irq rise 6 cycles after enable; TCOUNT reloads to 0.
//   Assert reset with mem_we=1 @0x010 -> RAM word unchanged; all outputs at reset values next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-side memory controller:
// MMIO offsets, access-size decode, timer control bits and load alignment.
package dmem_pkg;

  localparam logic [9:0] RAM_TOP = 10'h200;
  localparam logic [9:0] LED_A   = 10'h200;
  localparam logic [9:0] SW_A    = 10'h204;
  localparam logic [9:0] TCNT_A  = 10'h208;
  localparam logic [9:0] TCMP_A  = 10'h20C;
  localparam logic [9:0] TCTRL_A = 10'h210;
  localparam logic [9:0] STAT_A  = 10'h214;

  localparam int TC_EN  = 0;
  localparam int TC_AR  = 1;
  localparam int TC_IE  = 2;
  localparam int TC_CLR = 3;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  function automatic size_e size_dec(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return SZ_BYTE;
      3'd1, 3'd5: return SZ_HALF;
      default:    return SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] load_align(
    input logic [31:0] w,
    input size_e       sz,
    input logic [1:0]  off
  );
    logic [31:0] s;
    s = w;
    case (sz)
      SZ_BYTE: s = (w >> {off, 3'b000}) & 32'h0000_00FF;
      SZ_HALF: s = (w >> {off[1], 4'b0000}) & 32'h0000_FFFF;
      default: s = w;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Data RAM: 32-bit words, four byte enables,
// synchronous read returning the pre-write contents.
module dmem_ram #(
  parameter int WORDS = 128,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: RAM/MMIO decode, lane steering, LED/SW/STATUS.
// Timer (TCOUNT/TCMP/TCTRL) is built only when DMEM_TIMER_EN is defined.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS = 128,
  parameter int          IO_W      = 10,
  parameter logic [31:0] TMR_RST   = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_we,
  input  logic [9:0]      mem_addr,
  input  logic [2:0]      mem_size,
  input  logic [31:0]     mem_wdata,
  output logic [31:0]     mem_rdata,
  input  logic [IO_W-1:0] sw_in,
  output logic [IO_W-1:0] led_out,
  output logic            timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  size_e       sz;
  logic        mis;
  logic        in_ram;
  logic        is_reg;
  logic        sub_err;
  logic        reg_we;
  logic        ram_we;
  logic [3:0]  be;
  logic [31:0] lane_d;
  logic [31:0] ram_q;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_q;
  logic        rd_ok;
  logic        rd_ram;
  size_e       rd_sz;
  logic [1:0]  rd_off;
  logic [IO_W-1:0] sw_s1;
  logic [IO_W-1:0] sw_s2;
  logic [1:0]  status;
  logic [1:0]  st_clr;
  logic        match;

  assign sz     = size_dec(mem_size);
  assign mis    = (sz == SZ_HALF && mem_addr[0])
               || (sz == SZ_WORD && mem_addr[1:0] != 2'b00);
  assign in_ram = mem_addr < RAM_TOP;

`ifdef DMEM_TIMER_EN
  assign is_reg = mem_addr == LED_A || mem_addr == SW_A
               || mem_addr == STAT_A || mem_addr == TCNT_A
               || mem_addr == TCMP_A || mem_addr == TCTRL_A;
`else
  assign is_reg = mem_addr == LED_A || mem_addr == SW_A
               || mem_addr == STAT_A;
`endif

  assign sub_err = mem_we && !mis && sz != SZ_WORD && is_reg;
  assign reg_we  = mem_we && !mis && sz == SZ_WORD;
  assign ram_we  = mem_we && !mis && in_ram && !reset;

  always_comb begin
    be     = 4'hF;
    lane_d = mem_wdata;
    unique case (1'b1)
      sz == SZ_BYTE: begin
        be     = 4'b0001 << mem_addr[1:0];
        lane_d = {4{mem_wdata[7:0]}};
      end
      sz == SZ_HALF: begin
        be     = mem_addr[1] ? 4'b1100 : 4'b0011;
        lane_d = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  dmem_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be),
    .addr  (mem_addr[AW+1:2]),
    .wdata (lane_d),
    .rdata (ram_q)
  );

`ifdef DMEM_TIMER_EN
  logic [31:0] tcnt;
  logic [31:0] tcmp;
  logic [2:0]  tctrl;
  logic        t_clr;

  assign t_clr = reg_we && mem_addr == TCTRL_A && mem_wdata[TC_CLR];
  assign match = tctrl[TC_EN] && tcnt == tcmp;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      tcmp  <= TMR_RST;
      tctrl <= '0;
    end else begin
      if (reg_we && mem_addr == TCMP_A)  tcmp  <= mem_wdata;
      if (reg_we && mem_addr == TCTRL_A) tctrl <= mem_wdata[2:0];
      // clear strobe beats both reload and increment
      if (t_clr) tcnt <= '0;
      else if (tctrl[TC_EN])
        tcnt <= (match && tctrl[TC_AR]) ? '0 : tcnt + 32'd1;
    end
  end

  assign timer_irq = status[0] & tctrl[TC_IE];
`else
  assign match     = 1'b0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    mmio_rd = '0;
    case (mem_addr)
      LED_A:  mmio_rd[IO_W-1:0] = led_out;
      SW_A:   mmio_rd[IO_W-1:0] = sw_s2;
      STAT_A: mmio_rd[1:0]      = status;
`ifdef DMEM_TIMER_EN
      TCNT_A:  mmio_rd          = tcnt;
      TCMP_A:  mmio_rd          = tcmp;
      TCTRL_A: mmio_rd[2:0]     = tctrl;
`endif
      default: mmio_rd = '0;
    endcase
  end

  assign st_clr = (reg_we && mem_addr == STAT_A) ? mem_wdata[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      status  <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
      if (reg_we && mem_addr == LED_A) led_out <= mem_wdata[IO_W-1:0];
      // set wins over a same-cycle write-1-to-clear
      status <= (status & ~st_clr) | {mis | sub_err, match};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ok  <= 1'b0;
      rd_ram <= 1'b0;
      rd_sz  <= SZ_WORD;
      rd_off <= 2'b00;
      mmio_q <= '0;
    end else begin
      rd_ok  <= !mis;
      rd_ram <= in_ram;
      rd_sz  <= sz;
      rd_off <= mem_addr[1:0];
      mmio_q <= mmio_rd;
    end
  end

  assign mem_rdata = rd_ok
                   ? load_align(rd_ram ? ram_q : mmio_q, rd_sz, rd_off)
                   : 32'd0;

endmodule
